// File: rtl/adder_seq.sv
// Multi-cycle add/subtract unit: CHUNK bits per cycle, LSB first, flags {C,Z,N,V}.
// Optional carry/borrow-in port enabled by defining ADDER_SEQ_CARRY_IN_EN.
module adder_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int NCHUNK = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ADDER_SEQ_CARRY_IN_EN
  input  logic             cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       carryFlags
);

  localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               zacc_q;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         op_q;

  logic               carry_init;
  logic [CHUNK-1:0]   a_chunk, b_chunk;
  logic [CHUNK:0]     sum;
  logic [WIDTH-1:0]   result_d;
  logic [3:0]         flags_d;
  logic               last_chunk;

`ifdef ADDER_SEQ_CARRY_IN_EN
  // cin is a carry for add and a borrow for subtract.
  assign carry_init = op[0] ? ~cin : cin;
`else
  assign carry_init = op[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operands shift right one chunk per RUN cycle, so the active chunk is always the low one.
  assign a_chunk    = a_q[CHUNK-1:0];
  assign b_chunk    = b_q[CHUNK-1:0];
  assign sum        = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (cnt_q == LAST);

  if (NCHUNK > 1) begin : g_multi
    assign result_d = {sum[CHUNK-1:0], result_q[WIDTH-1:CHUNK]};
  end else begin : g_single
    assign result_d = sum[CHUNK-1:0];
  end

  // On the final chunk the low bits of a_q/b_q hold the operand sign bits.
  always_comb begin
    flags_d[3] = op_q[0] ? ~sum[CHUNK] : sum[CHUNK];
    flags_d[2] = zacc_q & ~|sum[CHUNK-1:0];
    flags_d[1] = op_q[1] & sum[CHUNK-1];
    flags_d[0] = op_q[1] & (a_chunk[CHUNK-1] == b_chunk[CHUNK-1])
                         & (sum[CHUNK-1] != a_chunk[CHUNK-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          cnt_q   <= '0;
          carry_q <= carry_init;
          zacc_q  <= 1'b1;
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= sum[CHUNK];
          zacc_q   <= zacc_q & ~|sum[CHUNK-1:0];
          cnt_q    <= last_chunk ? '0 : cnt_q + CNT_W'(1);
          if (last_chunk) flags_q <= flags_d;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q  <= A;
      b_q  <= op[0] ? ~B : B;
      op_q <= op;
    end else if (state_q == RUN) begin
      a_q <= a_q >> CHUNK;
      b_q <= b_q >> CHUNK;
    end
  end

  assign result     = result_q;
  assign carryFlags = flags_q;

endmodule

// File: tb/tb_adder_seq.sv
// Scoreboard bench for adder_seq (WIDTH=32, CHUNK=8).
module tb_adder_seq;
  localparam int W  = 32;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  A, B;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [3:0]    carryFlags;
`ifdef ADDER_SEQ_CARRY_IN_EN
  logic          cin = 1'b0;
`endif

  adder_seq #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B),
`ifdef ADDER_SEQ_CARRY_IN_EN
    .cin(cin),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryFlags(carryFlags)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W+3:0] exp_q[$];

  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] o);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, z, n, v;
    if (o[0]) begin
      r = a - b;
      c = (a < b);
      v = o[1] & (a[W-1] != b[W-1]) & (r[W-1] != a[W-1]);
    end else begin
      s = {1'b0, a} + {1'b0, b};
      r = s[W-1:0];
      c = s[W];
      v = o[1] & (a[W-1] == b[W-1]) & (r[W-1] != a[W-1]);
    end
    z = (r == '0);
    n = o[1] & r[W-1];
    return {r, c, z, n, v};
  endfunction

  // Presents an operation, waits for acceptance and optionally records the expectation.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                      input logic [W+3:0] exp, input bit push);
    int n = 0;
    A = a; B = b; op = o; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) exp_q.push_back(exp);
  endtask

  // Waits for out_valid; cyc counts edges from the accept edge (counted as 1).
  task automatic wait_out(output int cyc, output bit got);
    cyc = 1;
    while (!out_valid && cyc < 60) begin @(posedge clk); #1; cyc++; end
    got = out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== '0)       begin n_fail++; $display("FAIL rst_result: got %h want 0", result); end
    n_cmp++; if (carryFlags !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", carryFlags); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[8];
    logic [W-1:0] vb[8];
    logic [1:0]   vo[8];
    logic [W+3:0] ve[8];
    logic [W+3:0] e;
    int  cyc;
    bit  got;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1; vo[0] = 2'b00; ve[0] = {32'h0000_0000, 4'b1100};
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h1; vo[1] = 2'b10; ve[1] = {32'h8000_0000, 4'b0011};
    va[2] = 32'd5;         vb[2] = 32'd7; vo[2] = 2'b11; ve[2] = {32'hFFFF_FFFE, 4'b1010};
    va[3] = 32'h8000_0000; vb[3] = 32'h1; vo[3] = 2'b11; ve[3] = {32'h7FFF_FFFF, 4'b0001};
    va[4] = 32'h0000_1234; vb[4] = 32'h0000_1234; vo[4] = 2'b01;
    ve[4] = model(va[4], vb[4], vo[4]);
    for (int i = 5; i < 8; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vo[i] = 2'($urandom_range(0, 3));
      ve[i] = model(va[i], vb[i], vo[i]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(va[i], vb[i], vo[i], ve[i], 1'b1);
      wait_out(cyc, got);
      e = exp_q.pop_front();
      n_cmp++;
      if (!got) begin
        n_fail++; $display("FAIL vec%0d_valid: out_valid=%b want 1", i, out_valid);
      end else begin
        n_cmp++; if (cyc != NC + 1) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want %0d", i, cyc, NC + 1); end
        n_cmp++; if (result !== e[W+3:4]) begin n_fail++; $display("FAIL vec%0d_result: got %h want %h", i, result, e[W+3:4]); end
        n_cmp++; if (carryFlags !== e[3:0]) begin n_fail++; $display("FAIL vec%0d_flags: got %b want %b", i, carryFlags, e[3:0]); end
      end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_handoff: out_valid=%b want 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [W+3:0] e1, e2;
    int  cyc;
    bit  got;
    e1 = model(32'h0001_00FF, 32'h0000_0F01, 2'b00);
    e2 = model(32'd100, 32'd42, 2'b11);
    out_ready = 1'b0;
    send(32'h0001_00FF, 32'h0000_0F01, 2'b00, e1, 1'b1);
    wait_out(cyc, got);
    n_cmp++; if (!got) begin n_fail++; $display("FAIL bp_valid: out_valid=%b want 1", out_valid); end
    A = 32'd100; B = 32'd42; op = 2'b11; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b want 1,0", k, out_valid, in_ready); end
      n_cmp++; if (result !== e1[W+3:4] || carryFlags !== e1[3:0])
        begin n_fail++; $display("FAIL bp_stable%0d: got %h/%b want %h/%b", k, result, carryFlags, e1[W+3:4], e1[3:0]); end
    end
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_idle: in_ready=%b out_valid=%b want 1,0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(e2);
    wait_out(cyc, got);
    e2 = exp_q.pop_front();
    n_cmp++; if (!got || cyc != NC + 1)
      begin n_fail++; $display("FAIL bp_second_latency: got %0d want %0d", cyc, NC + 1); end
    n_cmp++; if (result !== e2[W+3:4] || carryFlags !== e2[3:0])
      begin n_fail++; $display("FAIL bp_second: got %h/%b want %h/%b", result, carryFlags, e2[W+3:4], e2[3:0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [W+3:0] e;
    int  cyc;
    bit  got;
    out_ready = 1'b1;
    send(32'hDEAD_BEEF, 32'h1111_1111, 2'b00, '0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL mid_rst_ctrl: in_ready=%b out_valid=%b want 1,0", in_ready, out_valid); end
    n_cmp++; if (result !== '0 || carryFlags !== 4'b0)
      begin n_fail++; $display("FAIL mid_rst_data: got %h/%b want 0/0000", result, carryFlags); end
    for (int k = 0; k < NC + 2; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ghost%0d: out_valid=%b want 0", k, out_valid); end
    end
    send(32'd3, 32'd4, 2'b00, {32'd7, 4'b0000}, 1'b1);
    wait_out(cyc, got);
    e = exp_q.pop_front();
    n_cmp++; if (!got || result !== e[W+3:4] || carryFlags !== e[3:0])
      begin n_fail++; $display("FAIL mid_rst_after: got %h/%b want %h/%b", result, carryFlags, e[W+3:4], e[3:0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] e;
    int  cyc;
    bit  got;
    int  t_prev, t_now;
    out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
      send(A, B, op, model(A, B, op), 1'b1);
      t_now = cyc_cnt;
      if (i > 0) begin
        n_cmp++; if (t_now - t_prev != NC + 2)
          begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want %0d", i, t_now - t_prev, NC + 2); end
      end
      t_prev = t_now;
      wait_out(cyc, got);
      e = exp_q.pop_front();
      n_cmp++; if (!got || result !== e[W+3:4] || carryFlags !== e[3:0])
        begin n_fail++; $display("FAIL b2b_result%0d: got %h/%b want %h/%b", i, result, carryFlags, e[W+3:4], e[3:0]); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
